// File: rtl/vm1_dma_pkg.sv
// vm1_dma_pkg
//   Shared definitions for the 1801VM1 DMA bus arbiter: the arbiter FSM
//   state encoding and the default DMGO wait limit.
package vm1_dma_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_REQ       = 3'd1,
        ARB_WAIT_FREE = 3'd2,
        ARB_OWN       = 3'd3,
        ARB_RELEASE   = 3'd4
    } arb_state_e;

    // pin_clk cycles to wait for DMGO before a request is abandoned
    localparam int unsigned REQ_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/vm1_dma_arbiter_rr_pick.sv
// vm1_rr_pick
//   Combinational round-robin picker. Selects the first set bit of req,
//   searching upward from index rr and wrapping around to 0.
//   Ports:
//     req   in   NREQ   request vector
//     rr    in   OWN_W  search start index (must be < NREQ)
//     found out  1      at least one request bit is set
//     idx   out  OWN_W  selected index (0 when nothing is set)
module vm1_rr_pick
    import vm1_dma_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned OWN_W = 1
)(
    input  logic [NREQ-1:0]  req,
    input  logic [OWN_W-1:0] rr,
    output logic             found,
    output logic [OWN_W-1:0] idx
);

    logic             found_hi;
    logic             found_lo;
    logic [OWN_W-1:0] idx_hi;
    logic [OWN_W-1:0] idx_lo;

    // Wrap-around search split into two priority scans: the lowest set bit
    // at or above rr wins, otherwise the lowest set bit overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (req[j] && (j >= 32'(rr)) && !found_hi) begin
                found_hi = 1'b1;
                idx_hi   = OWN_W'(j);
            end
            if (req[j] && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = OWN_W'(j);
            end
        end
        found = found_lo;
        idx   = found_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/vm1_dma_arbiter.sv
// vm1_dma_arbiter
//   Shares the 1801VM1 bus between the CPU core and NREQ on-chip DMA
//   masters. Runs the DMR/DMGO/SACK handshake with the core on behalf of
//   the requesters and grants the bus to one requester at a time with
//   round-robin priority. All outputs are registered.
//   Ports:
//     pin_clk     in   1      system clock
//     reset       in   1      synchronous, active-high reset
//     cpu_dmgo    in   1      DMA grant from CPU (pin_dmgo)
//     cpu_bsy     in   1      CPU bus busy (pin_bsy)
//     cpu_dmr     out  1      DMA request to CPU (pin_dmr)
//     cpu_sack    out  1      DMA acknowledge to CPU (pin_sack)
//     req         in   NREQ   per-requester bus request (level)
//     gnt         out  NREQ   per-requester grant, one-hot or zero
//     owner       out  OWN_W  index of current or pending owner
//     bus_dma     out  1      external mux select: 1 = DMA master, 0 = CPU
//     timeout_err out  1      one-cycle pulse when a request times out
module vm1_dma_arbiter
    import vm1_dma_pkg::*;
#(
    parameter  int unsigned NREQ        = 2,
    parameter  int unsigned REQ_TIMEOUT = REQ_TIMEOUT_DEFAULT,
    localparam int unsigned OWN_W       = (NREQ > 1) ? $clog2(NREQ) : 1
)(
    input  logic             pin_clk,
    input  logic             reset,
    input  logic             cpu_dmgo,
    input  logic             cpu_bsy,
    output logic             cpu_dmr,
    output logic             cpu_sack,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [OWN_W-1:0] owner,
    output logic             bus_dma,
    output logic             timeout_err
);

    localparam int unsigned      CNT_W    = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_TIMEOUT - 1);
    localparam logic [OWN_W-1:0] OWN_LAST = OWN_W'(NREQ - 1);

    arb_state_e       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_dmr_q, cpu_dmr_d;
    logic             cpu_sack_q, cpu_sack_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             bus_dma_q, bus_dma_d;
    logic             timeout_err_q, timeout_err_d;

    logic             pick_found;
    logic [OWN_W-1:0] pick_idx;
    logic [OWN_W-1:0] owner_inc;
    logic             req_own;

    vm1_rr_pick #(
        .NREQ  (NREQ),
        .OWN_W (OWN_W)
    ) u_pick (
        .req   (req),
        .rr    (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_inc = (owner_q == OWN_LAST) ? '0 : owner_q + OWN_W'(1);
    assign req_own   = req[owner_q];

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A withdrawn request beats a DMGO arriving in the same cycle.
                if (!req_own) begin
                    state_d = ARB_IDLE;
                end else if (cpu_dmgo) begin
                    state_d = ARB_WAIT_FREE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ARB_IDLE;
                    timeout_err_d = 1'b1;
                    rr_d          = owner_inc;
                end
            end
            ARB_WAIT_FREE: begin
                if (!req_own) begin
                    state_d = ARB_RELEASE;
                end else if (!cpu_bsy) begin
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (!req_own) begin
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                rr_d    = owner_inc;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // Outputs are a function of the state being entered, so they line
        // up with the state register without a separate output decode stage.
        cpu_dmr_d  = (state_d == ARB_REQ);
        cpu_sack_d = (state_d == ARB_WAIT_FREE) || (state_d == ARB_OWN) ||
                     (state_d == ARB_RELEASE);
        bus_dma_d  = (state_d == ARB_OWN);
        gnt_d      = bus_dma_d ? (NREQ'(1) << owner_d) : '0;
    end

    always_ff @(posedge pin_clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            owner_q       <= '0;
            rr_q          <= '0;
            cnt_q         <= '0;
            cpu_dmr_q     <= 1'b0;
            cpu_sack_q    <= 1'b0;
            gnt_q         <= '0;
            bus_dma_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            cnt_q         <= cnt_d;
            cpu_dmr_q     <= cpu_dmr_d;
            cpu_sack_q    <= cpu_sack_d;
            gnt_q         <= gnt_d;
            bus_dma_q     <= bus_dma_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cpu_dmr     = cpu_dmr_q;
    assign cpu_sack    = cpu_sack_q;
    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign bus_dma     = bus_dma_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/vm1_dma_arbiter.md
Name: vm1_dma_arbiter

Overview:
Shares the 1801VM1 bus between the CPU core and up to NREQ on-chip DMA masters (floppy, video refresh, etc.). It runs the CPU-side DMR/DMGO/SACK handshake on the requesters' behalf and grants the bus to one requester at a time, using round-robin priority. It also drives the select for the external address/data/strobe mux. It sits beside the vm1_se wrapper and connects to its pin_dmr, pin_dmgo, pin_sack and pin_bsy.

Parameters:
NREQ, 2, number of DMA requesters (1..8).
REQ_TIMEOUT, 1024, pin_clk cycles to wait for DMGO before aborting a request.
OWN_W, $clog2(NREQ) with a minimum of 1, width of the owner index (derived, not overridable).

Ports:
pin_clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_dmgo  in  1  DMA grant from CPU (pin_dmgo)
cpu_bsy  in  1  CPU bus busy (pin_bsy)
cpu_dmr  out  1  DMA request to CPU (pin_dmr)
cpu_sack  out  1  DMA acknowledge to CPU (pin_sack)
req  in  NREQ  per-requester bus request, level; held until the transfer burst is finished
gnt  out  NREQ  per-requester grant, one-hot or zero
owner  out  OWN_W  index of the current or pending owner
bus_dma  out  1  1 = external bus mux selects the DMA master, 0 = selects the CPU
timeout_err  out  1  one-cycle pulse when a request is aborted on timeout

Behaviour:
- Reset: all outputs are 0, the FSM is IDLE, the round-robin pointer rr is 0, the counter is 0. Reset asserted mid-operation forces this state on the next edge. No release sequence is performed; the CPU sees DMR and SACK drop together.
- FSM states: IDLE, REQ, WAIT_FREE, OWN, RELEASE. All outputs are registered.
- IDLE: if any req bit is set, latch owner = first set bit searching from rr upward with wrap-around. Go to REQ, with cpu_dmr=1 from the next cycle. Clear the counter.
- REQ: cpu_dmr=1, and the counter increments every cycle.
  - req[owner]=0: cancel. Set cpu_dmr=0 and go to IDLE. This takes priority over a DMGO seen in the same cycle.
  - Otherwise cpu_dmgo=1: set cpu_sack=1 and cpu_dmr=0, go to WAIT_FREE.
  - Otherwise counter = REQ_TIMEOUT-1: set cpu_dmr=0, pulse timeout_err for 1 cycle, set rr=owner+1 (mod NREQ), go to IDLE.
- WAIT_FREE: cpu_sack=1. When cpu_bsy=0, assert gnt[owner]=1 and bus_dma=1 (both visible from the next cycle), go to OWN. If req[owner] drops here, go to RELEASE without granting.
- OWN: cpu_sack=1, gnt[owner]=1, bus_dma=1. Hold while req[owner]=1. Other requests are ignored, with no preemption. When req[owner]=0, drop gnt and bus_dma on the next edge and go to RELEASE.
- RELEASE: exactly one cycle with cpu_sack=1, gnt=0 and bus_dma=0, so the mux switches back before SACK drops. Then cpu_sack=0, rr=owner+1 (mod NREQ), go to IDLE. A new request cannot raise DMR earlier than one cycle after SACK falls.
- Grant latency from req rising in IDLE, with DMGO and bsy=0 immediate: DMR at +1, SACK at +1 after DMGO is sampled, gnt at +1 after bsy=0 is sampled.
- Invariants:
  - gnt has at most one bit set.
  - cpu_dmr and cpu_sack are never both 1.
  - bus_dma=1 if and only if gnt is nonzero.
  - owner is stable from REQ through RELEASE.
- req bits for non-owners may change at any time and only matter when the next IDLE decision is made.
- NREQ=1: round-robin degenerates to a fixed grant to index 0.
- cpu_dmgo and cpu_bsy come from the same pin_clk domain as the core, so they need no synchronisers.

Decomposition:
- Package vm1_dma_pkg holds the FSM state enum (ARB_IDLE, ARB_REQ, ARB_WAIT_FREE, ARB_OWN, ARB_RELEASE) and the default REQ_TIMEOUT constant.
- One sub-module: vm1_rr_pick, a combinational round-robin picker with inputs req and rr and outputs found and idx.

Test Plan:
1. Single requester: req[0] rises at t0, CPU model gives DMGO at t0+4, bsy=0 -> cpu_dmr high at t0+1..t0+4, cpu_sack high from t0+5, gnt=01 and bus_dma=1 at t0+6. req[0] drops at t1 -> gnt=0 at t1+1, cpu_sack=0 at t1+2.
2. Round-robin: req=11 continuously, 4 bursts -> grant order 0,1,0,1 with owner matching each burst. Never two gnt bits set at once.
3. Bus busy: DMGO is given while cpu_bsy=1 for 10 cycles -> cpu_sack high throughout, gnt stays 0 until 1 cycle after bsy falls.
4. Timeout: REQ_TIMEOUT=16, CPU never gives DMGO -> cpu_dmr high for exactly 16 cycles, timeout_err pulses once, FSM returns to IDLE, rr advances.
5. Cancel race: req[0] drops in the same cycle DMGO rises -> cpu_dmr=0 next cycle, no SACK and no gnt, state is IDLE.
6. Reset during OWN with gnt=10 -> the next cycle has all outputs 0 and rr=0. After reset, req=11 is granted to index 0 first.
